// File: rtl/data_link_pkg.sv
// data_link_pkg: shared types and helpers for the link receive path.
//   word_class_t : classification of a received link word.
//   lock_state_t : link lock tracker state.
//   bit_reverse  : reverses the low 'width' bits of a word (width <= 64).
package data_link_pkg;

  typedef enum logic [1:0] {
    WC_IDLE,
    WC_BX0,
    WC_DATA
  } word_class_t;

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } lock_state_t;

  localparam int unsigned MAX_REV_WIDTH = 64;

  function automatic logic [63:0] bit_reverse(input logic [63:0] x,
                                              input int unsigned width);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_REV_WIDTH; i++) begin
      if (i < width) r[6'(width - 1 - i)] = x[6'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_demux_impl_fifo.sv
// tagged_sync_fifo: synchronous FIFO storing a data word plus a routing tag.
//   push/push_data/push_tag : write side (ignored when full)
//   pop                     : read side (ignored when empty)
//   head_data/head_tag      : oldest entry, valid while !empty
//   full/empty              : occupancy flags
// Reset clears the pointers, flushing the contents immediately.
module tagged_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    do_push   = push && !full;
    do_pop    = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{tag: push_tag, data: push_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    head_data = mem_q[rd_ptr_q[AW-1:0]].data;
    head_tag  = mem_q[rd_ptr_q[AW-1:0]].tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/data_demux_impl.sv
// data_demux_impl: link receive demux.
//   tdata_in/tvalid_in/tready_in : deserialized link words (tready_in = room)
//   tdata_out/tvalid_out/tready_out : per-output AXIS payload streams
//   output_select      : destination of DATA words, sampled at classification
//   idle_word(_BX0)    : idle / BX0 patterns in the post-reversal domain
//   n_lock_words, n_unlock_errors, bx_period : lock and orbit-check settings
//   fc_linkReset       : force reacquisition
//   locked, fc_orbitSync, bx0_error : status and one-cycle pulses
//   error_count, drop_count : saturating BX0-error / bad-select counters
module data_demux_impl
  import data_link_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int N_OUTPUTS          = 2,
  parameter int INPUT_REVERSE_BITS = 1,
  parameter int FIFO_DEPTH         = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 tdata_in,
  input  logic                                  tvalid_in,
  output logic                                  tready_in,
  output logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0]  tdata_out,
  output logic [N_OUTPUTS-1:0]                  tvalid_out,
  input  logic [N_OUTPUTS-1:0]                  tready_out,
  input  logic [3:0]                            output_select,
  input  logic [DATA_WIDTH-1:0]                 idle_word,
  input  logic [DATA_WIDTH-1:0]                 idle_word_BX0,
  input  logic [15:0]                           n_lock_words,
  input  logic [7:0]                            n_unlock_errors,
  input  logic [15:0]                           bx_period,
  input  logic                                  fc_linkReset,
  output logic                                  locked,
  output logic                                  fc_orbitSync,
  output logic                                  bx0_error,
  output logic [15:0]                           error_count,
  output logic [15:0]                           drop_count
);

  localparam int unsigned TAG_W       = 4;
  localparam logic [4:0]  N_OUT_LIMIT = 5'(N_OUTPUTS);

  lock_state_t           state_q, state_d;
  word_class_t           word_cls;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [15:0]           lock_cnt_q, lock_cnt_d;
  logic [15:0]           bx_cnt_q, bx_cnt_d;
  logic [7:0]            consec_q, consec_d;
  logic                  armed_q, armed_d;
  logic                  orbit_q, orbit_d;
  logic                  bxerr_q, bxerr_d;
  logic [15:0]           error_count_q, error_count_d;
  logic [15:0]           drop_count_q, drop_count_d;

  logic [DATA_WIDTH-1:0] word_in;
  logic [DATA_WIDTH-1:0] head_data;
  logic [TAG_W-1:0]      head_tag;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                  accept, s1_fire, bx_err;
  logic [15:0]           lock_thr, lock_inc;
  logic [7:0]            unlock_thr;

  // Stage 1 stalls only when it holds a word and the buffer is full, so the
  // buffer plus the in-flight word never overflow.
  assign tready_in = !(s1_valid_q && fifo_full);
  assign accept    = tvalid_in && tready_in;
  assign s1_fire   = s1_valid_q && !fifo_full;
  assign fifo_pop  = |(tvalid_out & tready_out);

  assign lock_thr   = (n_lock_words == '0) ? 16'd1 : n_lock_words;
  assign unlock_thr = (n_unlock_errors == '0) ? 8'd1 : n_unlock_errors;

  always_comb begin
    if (INPUT_REVERSE_BITS != 0) word_in = DATA_WIDTH'(bit_reverse(64'(tdata_in), DATA_WIDTH));
    else                         word_in = tdata_in;
  end

  always_comb begin
    for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
      tdata_out[i]  = head_data;
      tvalid_out[i] = !fifo_empty && (head_tag == TAG_W'(i));
    end
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    bx_cnt_d      = bx_cnt_q;
    consec_d      = consec_q;
    armed_d       = armed_q;
    orbit_d       = 1'b0;
    bxerr_d       = 1'b0;
    error_count_d = error_count_q;
    drop_count_d  = drop_count_q;
    fifo_push     = 1'b0;
    lock_inc      = lock_cnt_q;
    bx_err        = 1'b0;

    // BX0 pattern wins over the idle pattern.
    word_cls = WC_DATA;
    if (s1_data_q == idle_word_BX0)  word_cls = WC_BX0;
    else if (s1_data_q == idle_word) word_cls = WC_IDLE;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = word_in;
    end else if (s1_valid_q && (!fifo_full || fc_linkReset)) begin
      s1_valid_d = 1'b0;
    end

    if (fc_linkReset) begin
      state_d    = ST_UNLOCKED;
      lock_cnt_d = '0;
      bx_cnt_d   = '0;
      consec_d   = '0;
      armed_d    = 1'b0;
    end else if (s1_fire) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (word_cls == WC_DATA) begin
            lock_cnt_d = '0;
          end else begin
            lock_inc   = (lock_cnt_q >= lock_thr) ? lock_thr : lock_cnt_q + 16'd1;
            lock_cnt_d = lock_inc;
            if (lock_inc >= lock_thr) begin
              state_d  = ST_LOCKED;
              bx_cnt_d = '0;
              consec_d = '0;
              // Locking on a BX0 starts the orbit window right away;
              // otherwise the window opens at the first BX0 seen.
              armed_d  = (word_cls == WC_BX0);
            end
          end
        end
        ST_LOCKED: begin
          if (word_cls == WC_BX0) begin
            if (bx_period == '0) begin
              orbit_d = 1'b1;
            end else if (!armed_q || (bx_cnt_q == bx_period - 16'd1)) begin
              orbit_d  = 1'b1;
              consec_d = '0;
              bx_cnt_d = '0;
              armed_d  = 1'b1;
            end else begin
              bx_err = 1'b1;
            end
          end else begin
            if (word_cls == WC_DATA) begin
              if ({1'b0, output_select} < N_OUT_LIMIT) fifo_push = 1'b1;
              else if (drop_count_q != '1)             drop_count_d = drop_count_q + 16'd1;
            end
            if ((bx_period != '0) && armed_q) begin
              if (bx_cnt_q + 16'd1 == bx_period) bx_err = 1'b1;
              else                               bx_cnt_d = bx_cnt_q + 16'd1;
            end
          end
          if (bx_err) begin
            bxerr_d  = 1'b1;
            bx_cnt_d = '0;
            if (error_count_q != '1) error_count_d = error_count_q + 16'd1;
            if (consec_q + 8'd1 >= unlock_thr) begin
              state_d    = ST_UNLOCKED;
              lock_cnt_d = '0;
              consec_d   = '0;
              armed_d    = 1'b0;
            end else begin
              consec_d = consec_q + 8'd1;
            end
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_UNLOCKED;
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      lock_cnt_q    <= '0;
      bx_cnt_q      <= '0;
      consec_q      <= '0;
      armed_q       <= 1'b0;
      orbit_q       <= 1'b0;
      bxerr_q       <= 1'b0;
      error_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      lock_cnt_q    <= lock_cnt_d;
      bx_cnt_q      <= bx_cnt_d;
      consec_q      <= consec_d;
      armed_q       <= armed_d;
      orbit_q       <= orbit_d;
      bxerr_q       <= bxerr_d;
      error_count_q <= error_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign locked       = (state_q == ST_LOCKED);
  assign fc_orbitSync = orbit_q;
  assign bx0_error    = bxerr_q;
  assign error_count  = error_count_q;
  assign drop_count   = drop_count_q;

  tagged_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (s1_data_q),
    .push_tag  (output_select),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_tag  (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_data_demux_impl.sv
module tb_data_demux_impl;

  localparam logic [31:0] IDLE = 32'h5CCCCCCC;
  localparam logic [31:0] BX0W = 32'h5CCCBCBC;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      tdata_in;
  logic             tvalid_in;
  logic             tready_in;
  logic [1:0][31:0] tdata_out;
  logic [1:0]       tvalid_out;
  logic [1:0]       tready_out;
  logic [3:0]       output_select;
  logic [31:0]      idle_word, idle_word_BX0;
  logic [15:0]      n_lock_words;
  logic [7:0]       n_unlock_errors;
  logic [15:0]      bx_period;
  logic             fc_linkReset;
  logic             locked, fc_orbitSync, bx0_error;
  logic [15:0]      error_count, drop_count;

  always #5 clk = ~clk;

  data_demux_impl #(
    .DATA_WIDTH         (32),
    .N_OUTPUTS          (2),
    .INPUT_REVERSE_BITS (1),
    .FIFO_DEPTH         (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tdata_in        (tdata_in),
    .tvalid_in       (tvalid_in),
    .tready_in       (tready_in),
    .tdata_out       (tdata_out),
    .tvalid_out      (tvalid_out),
    .tready_out      (tready_out),
    .output_select   (output_select),
    .idle_word       (idle_word),
    .idle_word_BX0   (idle_word_BX0),
    .n_lock_words    (n_lock_words),
    .n_unlock_errors (n_unlock_errors),
    .bx_period       (bx_period),
    .fc_linkReset    (fc_linkReset),
    .locked          (locked),
    .fc_orbitSync    (fc_orbitSync),
    .bx0_error       (bx0_error),
    .error_count     (error_count),
    .drop_count      (drop_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: consumes words in acceptance order (the link rules are
  // order-based, so pipeline timing does not matter to it).
  typedef struct {
    logic [31:0] d;
    int unsigned sel;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_locked = 0, m_armed = 0;
  int unsigned m_run = 0, m_since = 0, m_consec = 0;
  int unsigned m_errs = 0, m_drops = 0, m_orbits = 0, m_bxerrs = 0;
  int unsigned obs_orbits = 0, obs_bxerrs = 0;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31 - i];
    return r;
  endfunction

  function automatic void model_error();
    int unsigned uthr;
    uthr = (n_unlock_errors == 0) ? 1 : 32'(n_unlock_errors);
    m_bxerrs++;
    if (m_errs < 65535) m_errs++;
    m_since = 0;
    m_consec++;
    if (m_consec >= uthr) begin
      m_locked = 0;
      m_run    = 0;
      m_consec = 0;
      m_armed  = 0;
    end
  endfunction

  function automatic void model_accept(input logic [31:0] w);
    int unsigned lthr;
    bit   is_bx0, is_idle;
    exp_t e;
    lthr    = (n_lock_words == 0) ? 1 : 32'(n_lock_words);
    is_bx0  = (w == BX0W);
    is_idle = !is_bx0 && (w == IDLE);
    if (!m_locked) begin
      if (is_bx0 || is_idle) begin
        if (m_run < lthr) m_run++;
        if (m_run >= lthr) begin
          m_locked = 1;
          m_since  = 0;
          m_consec = 0;
          m_armed  = is_bx0;
        end
      end else begin
        m_run = 0;
      end
    end else if (is_bx0) begin
      if (bx_period == 0) m_orbits++;
      else if (!m_armed || m_since == 32'(bx_period) - 1) begin
        m_orbits++;
        m_consec = 0;
        m_since  = 0;
        m_armed  = 1;
      end else model_error();
    end else begin
      if (!is_idle) begin
        if (32'(output_select) < 2) begin
          e.d   = w;
          e.sel = 32'(output_select);
          exp_q.push_back(e);
        end else if (m_drops < 65535) m_drops++;
      end
      if (bx_period != 0 && m_armed) begin
        m_since++;
        if (m_since == 32'(bx_period)) model_error();
      end
    end
  endfunction

  function automatic void model_link_reset();
    m_locked = 0;
    m_run    = 0;
    m_since  = 0;
    m_consec = 0;
    m_armed  = 0;
  endfunction

  // Drive a raw link word at the negedge and hold it until the DUT is ready;
  // it is taken at the following posedge.
  task automatic send_raw(input logic [31:0] raw);
    int unsigned n;
    n = 0;
    @(negedge clk);
    tdata_in  = raw;
    tvalid_in = 1'b1;
    while (!tready_in && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 4) tready_out = 2'b11;
    end
    if (!tready_in) begin
      check("send_ready_timeout", 32'(tready_in), 1);
      tvalid_in = 1'b0;
    end else begin
      model_accept(rev32(raw));
    end
  endtask

  task automatic send_word(input logic [31:0] logical);
    send_raw(rev32(logical));
  endtask

  task automatic settle(input int unsigned n);
    @(negedge clk);
    tvalid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] w;
    w = $urandom;
    if (w == IDLE || w == BX0W) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic check_state();
    check("locked", 32'(locked), 32'(m_locked));
    check("error_count", 32'(error_count), m_errs);
    check("drop_count", 32'(drop_count), m_drops);
    check("orbit_pulses", obs_orbits, m_orbits);
    check("bx0err_pulses", obs_bxerrs, m_bxerrs);
  endtask

  // Output monitor: samples just after the inactive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset !== 1'b1) begin
        if (fc_orbitSync) obs_orbits++;
        if (bx0_error) obs_bxerrs++;
        if (tvalid_out != 2'b00) check("out_onehot", 32'($countones(tvalid_out)), 1);
        for (int i = 0; i < 2; i++) begin
          if (tvalid_out[i] && tready_out[i]) begin
            check("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("out_data", tdata_out[i], e.d);
              check("out_port", 32'(i), e.sel);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [31:0] w;
    int unsigned r;

    reset           = 1'b1;
    tdata_in        = '0;
    tvalid_in       = 1'b0;
    tready_out      = 2'b11;
    output_select   = 4'd0;
    idle_word       = IDLE;
    idle_word_BX0   = BX0W;
    n_lock_words    = 16'd4;
    n_unlock_errors = 8'd2;
    bx_period       = 16'd8;
    fc_linkReset    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid_out", 32'(tvalid_out), 0);
    check("rst_tready_in", 32'(tready_in), 1);
    check("rst_locked", 32'(locked), 0);
    check("rst_orbit", 32'(fc_orbitSync), 0);
    check("rst_bx0err", 32'(bx0_error), 0);
    check("rst_error_count", 32'(error_count), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    reset = 1'b0;

    // Lock acquisition: not locked after 3 idles, locked after the 4th
    repeat (3) send_word(IDLE);
    settle(3);
    check("lock_after_3", 32'(locked), 0);
    send_word(IDLE);
    settle(3);
    check("lock_after_4", 32'(locked), 1);
    send_word(IDLE);

    // Orbits of 8 words; first payload word checks the 2-cycle latency
    for (int o = 0; o < 3; o++) begin
      send_word(BX0W);
      if (o == 0) begin
        send_word(rand_data());
        @(negedge clk);
        tvalid_in = 1'b0;
        check("lat_t1_valid", 32'(tvalid_out), 0);
        @(negedge clk);
        check("lat_t2_valid", 32'(tvalid_out), 32'h1);
        repeat (6) send_word(rand_data());
      end else begin
        repeat (7) send_word(rand_data());
      end
    end
    send_word(BX0W);
    settle(5);
    check_state();

    // Early BX0 twice -> two errors and loss of lock, then relock
    repeat (2) begin
      repeat (4) send_word(rand_data());
      send_word(BX0W);
    end
    settle(5);
    check("err_count_two", 32'(error_count), 2);
    check("err_unlocked", 32'(locked), 0);
    check_state();
    repeat (4) send_word(IDLE);
    settle(4);
    check("relock", 32'(locked), 1);

    // Backpressure on output 1
    output_select = 4'd1;
    tready_out    = 2'b01;
    repeat (3) send_word(rand_data());
    w = rand_data();
    @(negedge clk);
    tdata_in  = rev32(w);
    tvalid_in = 1'b1;
    check("bp_ready_low", 32'(tready_in), 0);
    repeat (9) @(negedge clk);
    check("bp_ready_held_low", 32'(tready_in), 0);
    check("bp_valid_held", 32'(tvalid_out), 32'h2);
    tready_out = 2'b11;
    send_word(w);
    repeat (4) send_word(rand_data());
    settle(6);
    check("bp_drained", exp_q.size(), 0);
    check_state();

    // Out-of-range select drops the payload
    output_select = 4'd5;
    repeat (3) send_word(rand_data());
    settle(5);
    check("inv_drop_count", 32'(drop_count), 3);
    check_state();

    // Link reset with two words buffered
    output_select = 4'd0;
    tready_out    = 2'b10;
    repeat (2) send_word(rand_data());
    settle(4);
    @(negedge clk);
    fc_linkReset = 1'b1;
    model_link_reset();
    @(negedge clk);
    fc_linkReset = 1'b0;
    check("lr_unlocked", 32'(locked), 0);
    check("lr_valid_held", 32'(tvalid_out), 32'h1);
    tready_out = 2'b11;
    settle(5);
    check("lr_drained", exp_q.size(), 0);
    check_state();

    // Raw 0x3333333A reverses to the idle pattern and completes the lock
    repeat (3) send_word(IDLE);
    send_raw(32'h3333333A);
    settle(4);
    check("rev_idle_locks", 32'(locked), 1);
    check_state();

    // Randomized bursts
    for (int b = 0; b < 12; b++) begin
      n_lock_words    = 16'($urandom_range(1, 3));
      n_unlock_errors = 8'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) bx_period = 16'd0;
      else                           bx_period = 16'($urandom_range(3, 5));
      output_select = 4'($urandom_range(0, 2));
      for (int k = 0; k < 30; k++) begin
        r = $urandom_range(0, 9);
        if (r < 3)      w = IDLE;
        else if (r < 5) w = BX0W;
        else            w = rand_data();
        tready_out = 2'($urandom_range(0, 3));
        send_word(w);
      end
      tready_out = 2'b11;
      settle(6);
      check("rand_drained", exp_q.size(), 0);
      check_state();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_demux_impl.md
Name: data_demux_impl

Overview:
- Receive-side counterpart of the link-output mux. Takes the deserialized word stream from a link and strips idle and BX0-idle words.
- Acquires and tracks link lock from the idle pattern and checks the BX0 period.
- Regenerates the orbit-sync pulse from received BX0 words.
- Routes payload words to one of N AXIS outputs through a small tagged buffer.

Parameters:
- DATA_WIDTH, 32, link word width.
- N_OUTPUTS, 2, number of AXIS outputs, 1..16.
- INPUT_REVERSE_BITS, 1, bit-reverse each input word before classification (undoes the transmit-side reversal).
- FIFO_DEPTH, 2, output buffer entries (power of 2, >=2).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- tdata_in  in  DATA_WIDTH  link word.
- tvalid_in  in  1  word valid.
- tready_in  out  1  buffer not full.
- tdata_out  out  [N_OUTPUTS] x DATA_WIDTH  per-output payload.
- tvalid_out  out  [N_OUTPUTS] x 1  per-output valid.
- tready_out  in  [N_OUTPUTS] x 1  per-output ready.
- output_select  in  4  destination output index.
- idle_word  in  DATA_WIDTH  idle pattern (post-reversal domain).
- idle_word_BX0  in  DATA_WIDTH  BX0 idle pattern.
- n_lock_words  in  16  consecutive idles needed to lock.
- n_unlock_errors  in  8  consecutive BX0 errors that drop lock.
- bx_period  in  16  accepted words per orbit; 0 disables the check.
- fc_linkReset  in  1  forces reacquisition.
- locked  out  1  lock status.
- fc_orbitSync  out  1  one-cycle pulse per good BX0.
- bx0_error  out  1  one-cycle pulse per BX0 error.
- error_count  out  16  saturating total BX0 errors.
- drop_count  out  16  saturating payload words dropped for an invalid select.

Behaviour:
- Reset values: tvalid_out all 0; tready_in 1; locked 0; pulses 0; counters 0; FSM UNLOCKED; buffer empty.
- Acceptance: a word is accepted when tvalid_in && tready_in. tready_in = !full.
- Stage 1 registers the accepted word, bit-reversed if INPUT_REVERSE_BITS.
- Stage 2 classifies the word as BX0 (==idle_word_BX0, checked first), IDLE (==idle_word), or DATA.
- Latency: a DATA word accepted in cycle t shows on tvalid_out in cycle t+2 when the buffer is empty.
- Full handling: tready_in deasserts when the buffer plus the in-flight stage would overflow. The accept path must never lose a word.
- FSM UNLOCKED:
  - IDLE or BX0 increments lock_cnt; DATA clears lock_cnt and is discarded (not counted).
  - Transition to LOCKED when lock_cnt reaches max(n_lock_words,1).
  - On entry to LOCKED: bx_cnt=0 if the entering word was BX0, else the check is armed at the first BX0.
- FSM LOCKED:
  - IDLE is dropped.
  - DATA is pushed with tag output_select, sampled at stage 2.
  - BX0 is dropped and handled by the BX0 check below.
- BX0 check (bx_period != 0): bx_cnt counts accepted words since the last BX0, including idles.
  - BX0 with bx_cnt==bx_period-1, or the first BX0 after lock: fc_orbitSync=1, consec_err=0, bx_cnt=0.
  - BX0 at any other bx_cnt: bx0_error=1, error_count++, consec_err++, bx_cnt=0, no orbitSync.
  - bx_cnt reaching bx_period without a BX0: bx0_error=1, error_count++, consec_err++, bx_cnt=0.
  - consec_err reaching max(n_unlock_errors,1): go to UNLOCKED, lock_cnt=0, locked=0 next cycle.
- BX0 check disabled (bx_period==0): every BX0 pulses fc_orbitSync; no errors.
- Routing:
  - Buffer head drives only tdata_out[tag]/tvalid_out[tag]; other tvalid_out are 0.
  - Head pops on tvalid_out[tag] && tready_out[tag]. Only one output is valid at a time; head-of-line blocking is intended.
  - tdata_out on non-selected outputs mirrors the head data (don't-care).
- Invalid select: output_select >= N_OUTPUTS means the word is not pushed; drop_count++ (saturating).
- Simultaneous events:
  - fc_linkReset has priority: FSM to UNLOCKED; lock_cnt, bx_cnt, consec_err cleared; the stage-2 word is discarded.
  - Buffered words still drain with AXIS valid held stable.
  - error_count and drop_count are kept; only reset clears them.
- Reset mid-transfer: the buffer is flushed immediately (reset overrides AXIS stability).
- Counters saturate at 0xFFFF; lock_cnt saturates at its threshold.

Decomposition:
- Package data_link_pkg holds:
  - enum word_class_t {WC_IDLE, WC_BX0, WC_DATA};
  - enum lock_state_t {ST_UNLOCKED, ST_LOCKED};
  - function bit_reverse.
- One sub-module, tagged_sync_fifo: a parameterised data+tag synchronous FIFO with full/empty flags.

Test Plan:
- n_lock_words=4, bx_period=8, 5 idles then BX0 every 8 words with data in between -> locked=1 after the 4th idle, one fc_orbitSync per BX0, data on output_select only, latency 2.
- Locked; BX0 arrives at word 5 of 8, n_unlock_errors=2, twice -> bx0_error pulses twice, error_count=2, locked=0 after the second; then 4 idles -> relock.
- output_select=1, tready_out[1]=0 for 10 cycles under continuous DATA -> tready_in drops after 3 words accepted, nothing lost, in-order drain on release.
- output_select=5 with N_OUTPUTS=2, 3 DATA words -> no tvalid_out, drop_count=3.
- fc_linkReset while 2 words are buffered -> locked=0 next cycle, both words still delivered, error_count unchanged.
- INPUT_REVERSE_BITS=1, input word 32'h3333333A (reversal of idle 0x5CCCCCCC) -> classified idle, not forwarded.
